// File: rtl/uart_bus_pkg.sv
// Shared constants and state types for the UART bus bridge.
package uart_bus_pkg;

  // Register select values taken from addr[3:2].
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS register bit positions.
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_AVAIL  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_ACTIVE = 4;
  localparam int ST_RX_OVR    = 5;
  localparam int ST_TX_OVF    = 6;

  // CTRL register bit positions.
  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_STROBE,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_CAPTURE,
    RX_ACK,
    RX_WAIT_CLR
  } rx_state_e;

endpackage

// File: rtl/uart_bus_bridge_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// CPU-side register bridge for the uart: TX/RX FIFOs, strobe/acknowledge FSMs and a level interrupt.
module uart_bus_bridge
  import uart_bus_pkg::*;
#(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int SS_CYCLES = 2,
  parameter int RR_CYCLES = 2,
  parameter int BUSY_TMO  = 8
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        uart_ss,
  output logic [7:0]  uart_data,
  input  logic        uart_busy,
  input  logic [7:0]  uart_rec_data,
  input  logic        uart_rec_valid,
  output logic        uart_rr
);

  localparam logic [7:0] SS_LAST  = 8'(SS_CYCLES - 1);
  localparam logic [7:0] RR_LAST  = 8'(RR_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);

  logic busy_meta_q, busy_s_q, rv_meta_q, rv_s_q;
  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [7:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]  uart_data_q, uart_data_d;
  logic        uart_ss_q, uart_rr_q, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d, status_w;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;

  logic        tx_pop, tx_full, tx_empty, tx_active;
  logic [7:0]  tx_dout;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic        rx_push, rx_pop, rx_full, rx_empty, rx_avail;
  logic [7:0]  rx_dout;
  logic [$clog2(RX_DEPTH):0] rx_count;

  logic [1:0] reg_sel;
  logic       wr_data, wr_status, wr_ctrl;
  logic       unused_bits;

  assign reg_sel     = addr[3:2];
  assign wr_data     = wr_en && (reg_sel == REG_DATA);
  assign wr_status   = wr_en && (reg_sel == REG_STATUS);
  assign wr_ctrl     = wr_en && (reg_sel == REG_CTRL);
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign tx_active = (tx_state_q != TX_IDLE);
  assign rx_avail  = (rx_count != '0);

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(sclk), .rst_i(reset), .push_i(wr_data), .din_i(wdata[7:0]), .pop_i(tx_pop),
    .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(sclk), .rst_i(reset), .push_i(rx_push), .din_i(uart_rec_data), .pop_i(rx_pop),
    .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  // TX sequencing: load a byte, strobe it, then follow the uart's busy handshake.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    uart_data_d = uart_data_q;
    tx_pop      = 1'b0;
    case (tx_state_q)
      TX_IDLE:   if (tx_count != '0) tx_state_d = TX_LOAD;
      TX_LOAD: begin
        tx_pop      = 1'b1;
        uart_data_d = tx_dout;
        tx_cnt_d    = '0;
        tx_state_d  = TX_STROBE;
      end
      TX_STROBE: begin
        if (tx_cnt_q == SS_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_WAIT_HI;
        end else begin
          tx_cnt_d = tx_cnt_q + 8'd1;
        end
      end
      // A uart that never reports busy must not stall the queue forever.
      TX_WAIT_HI: begin
        if (busy_s_q || (tx_cnt_q == TMO_LAST)) tx_state_d = TX_WAIT_LO;
        else tx_cnt_d = tx_cnt_q + 8'd1;
      end
      TX_WAIT_LO: if (!busy_s_q) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  // RX sequencing: one capture per rec_valid assertion, then acknowledge and wait for it to clear.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE:    if (rv_s_q) rx_state_d = RX_CAPTURE;
      RX_CAPTURE: begin
        rx_push    = 1'b1;
        rx_cnt_d   = '0;
        rx_state_d = RX_ACK;
      end
      RX_ACK: begin
        if (rx_cnt_q == RR_LAST) rx_state_d = RX_WAIT_CLR;
        else rx_cnt_d = rx_cnt_q + 8'd1;
      end
      RX_WAIT_CLR: if (!rv_s_q) rx_state_d = RX_IDLE;
      default:    rx_state_d = RX_IDLE;
    endcase
  end

  // Register reads, RX pop on DATA read, sticky flags (set beats clear) and interrupt.
  always_comb begin
    status_w               = '0;
    status_w[ST_TX_FULL]   = tx_full;
    status_w[ST_TX_EMPTY]  = tx_empty;
    status_w[ST_RX_AVAIL]  = rx_avail;
    status_w[ST_RX_FULL]   = rx_full;
    status_w[ST_TX_ACTIVE] = tx_active;
    status_w[ST_RX_OVR]    = rx_ovr_q;
    status_w[ST_TX_OVF]    = tx_ovf_q;

    rdata_d = rdata_q;
    rx_pop  = 1'b0;
    if (rd_en) begin
      case (reg_sel)
        REG_DATA: begin
          if (!rx_empty) begin
            rdata_d = {24'b0, rx_dout};
            rx_pop  = 1'b1;
          end else begin
            rdata_d = '0;
          end
        end
        REG_STATUS: rdata_d = status_w;
        REG_CTRL:   rdata_d = {30'b0, ctrl_q};
        default:    rdata_d = '0;
      endcase
    end

    ctrl_d   = wr_ctrl ? wdata[1:0] : ctrl_q;
    tx_ovf_d = (wr_data && tx_full && !tx_pop) ||
               (tx_ovf_q && !(wr_status && wdata[ST_TX_OVF]));
    rx_ovr_d = (rx_push && rx_full && !rx_pop) ||
               (rx_ovr_q && !(wr_status && wdata[ST_RX_OVR]));
    irq_d    = (ctrl_q[CTRL_RX_IRQ_EN] && rx_avail) ||
               (ctrl_q[CTRL_TX_IRQ_EN] && tx_empty && !tx_active);
  end

  // Two-flop synchronizers for the uart's asynchronous status lines.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      rv_meta_q   <= 1'b0;
      rv_s_q      <= 1'b0;
    end else begin
      busy_meta_q <= uart_busy;
      busy_s_q    <= busy_meta_q;
      rv_meta_q   <= uart_rec_valid;
      rv_s_q      <= rv_meta_q;
    end
  end

  // State, counters and registered outputs; reset drops ss/rr immediately.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      rx_state_q  <= RX_IDLE;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      uart_data_q <= '0;
      uart_ss_q   <= 1'b0;
      uart_rr_q   <= 1'b0;
      rdata_q     <= '0;
      ctrl_q      <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      uart_data_q <= uart_data_d;
      uart_ss_q   <= (tx_state_d == TX_STROBE);
      uart_rr_q   <= (rx_state_d == RX_ACK);
      rdata_q     <= rdata_d;
      ctrl_q      <= ctrl_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovr_q    <= rx_ovr_d;
      irq_q       <= irq_d;
    end
  end

  assign rdata     = rdata_q;
  assign irq       = irq_q;
  assign uart_ss   = uart_ss_q;
  assign uart_data = uart_data_q;
  assign uart_rr   = uart_rr_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus queues expected bytes/reads, monitors compare.
module tb_uart_bus_bridge;

  logic        sclk = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic        wr_en, rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq, uart_ss, uart_rr;
  logic [7:0]  uart_data;
  logic        uart_busy;
  logic [7:0]  uart_rec_data;
  logic        uart_rec_valid;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd[$];
  logic        busy_stuck = 1'b0;

  uart_bus_bridge dut (
    .sclk(sclk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .irq(irq), .uart_ss(uart_ss), .uart_data(uart_data),
    .uart_busy(uart_busy), .uart_rec_data(uart_rec_data), .uart_rec_valid(uart_rec_valid),
    .uart_rr(uart_rr)
  );

  always #5 sclk = ~sclk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_event(string name);
    checks++;
    errors++;
    $display("FAIL %s: got event-missing expected event-seen", name);
  endfunction

  // Read-data monitor: rdata is compared the cycle after each sampled rd_en.
  initial begin
    logic pend;
    forever begin
      @(posedge sclk);
      pend = rd_en && !reset;
      @(negedge sclk);
      if (pend) begin
        if (exp_rd.size() == 0) fail_event("rdata_unexpected");
        else begin
          $display("read rdata=0x%0h", rdata);
          check("rdata", rdata, exp_rd.pop_front());
        end
      end
    end
  end

  // Strobe/acknowledge monitor: byte value at each ss rise, pulse widths of ss and rr.
  initial begin
    int ss_w = 0;
    int rr_w = 0;
    logic ss_prev = 1'b0;
    logic rr_prev = 1'b0;
    forever begin
      @(negedge sclk);
      if (uart_ss && !ss_prev) begin
        if (exp_tx.size() == 0) fail_event("tx_unexpected");
        else begin
          $display("tx byte=0x%0h", uart_data);
          check("uart_data", {24'b0, uart_data}, {24'b0, exp_tx.pop_front()});
        end
      end
      if (uart_ss) ss_w++;
      else if (ss_prev) begin
        check("ss_width", 32'(ss_w), 32'd2);
        ss_w = 0;
      end
      if (uart_rr) rr_w++;
      else if (rr_prev) begin
        check("rr_width", 32'(rr_w), 32'd2);
        rr_w = 0;
      end
      ss_prev = uart_ss;
      rr_prev = uart_rr;
    end
  end

  // Uart transmitter model: busy for 20 cycles after each strobe, or held high on demand.
  initial begin
    int busy_cnt = 0;
    logic ss_seen = 1'b0;
    uart_busy = 1'b0;
    forever begin
      @(posedge sclk);
      #1;
      if (uart_ss && !ss_seen) busy_cnt = 20;
      ss_seen = uart_ss;
      if (busy_cnt > 0) begin
        uart_busy = 1'b1;
        busy_cnt--;
      end else begin
        uart_busy = busy_stuck;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Bus helpers assume the caller sits just after a rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge sclk); #1;
    wr_en = 1'b0;
    $display("write addr=0x%0h data=0x%0h", a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
    exp_rd.push_back(exp);
    addr = a; rd_en = 1'b1;
    @(posedge sclk); #1;
    rd_en = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int n;
    uart_rec_data = b;
    uart_rec_valid = 1'b1;
    n = 0;
    while (!uart_rr && n < 40) begin tick(1); n++; end
    if (!uart_rr) fail_event("rr_rise_timeout");
    uart_rec_valid = 1'b0;
    n = 0;
    while (uart_rr && n < 40) begin tick(1); n++; end
    if (uart_rr) fail_event("rr_fall_timeout");
    tick(4);
    $display("rx byte=0x%0h delivered", b);
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while (exp_tx.size() != 0 && n < 3000) begin tick(1); n++; end
    if (exp_tx.size() != 0) fail_event("tx_drain_timeout");
    tick(40);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr = 4'h0; wdata = 32'hFF;
    uart_rec_valid = 1'b0; uart_rec_data = 8'h00;

    // 1. Reset with a write strobe held: outputs quiet, nothing queued.
    tick(3);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_ss", {31'b0, uart_ss}, 32'h0);
    check("reset_uart_data", {24'b0, uart_data}, 32'h0);
    check("reset_rr", {31'b0, uart_rr}, 32'h0);
    wr_en = 1'b0; reset = 1'b0;
    tick(1);
    bus_read(4'h4, 32'h02);

    // 2. Two bytes out; mid-transfer STATUS shows active with one byte still queued.
    exp_tx.push_back(8'h41); exp_tx.push_back(8'h42);
    bus_write(4'h0, 32'h41);
    bus_write(4'h0, 32'h42);
    tick(8);
    bus_read(4'h4, 32'h10);
    wait_tx_drain();
    bus_read(4'h4, 32'h02);

    // 3. One received byte, read back, then empty read returns 0.
    rx_byte(8'h5A);
    bus_read(4'h4, 32'h06);
    bus_read(4'h0, 32'h5A);
    bus_read(4'h0, 32'h00);
    bus_read(4'h4, 32'h02);

    // 4. Busy stuck high: first byte goes out, 16 fill the FIFO, the last write overflows.
    busy_stuck = 1'b1;
    for (int i = 0; i < 18; i++) begin
      addr = 4'h0; wdata = 32'(8'h10 + i); wr_en = 1'b1;
      if (i < 17) exp_tx.push_back(8'(8'h10 + i));
      tick(1);
    end
    wr_en = 1'b0;
    tick(4);
    bus_read(4'h4, 32'h51);
    bus_write(4'h4, 32'h40);
    bus_read(4'h4, 32'h11);
    busy_stuck = 1'b0;
    wait_tx_drain();
    bus_read(4'h4, 32'h02);

    // 5. 17 receives: FIFO full with overrun, first 16 read back in order.
    for (int i = 0; i < 17; i++) rx_byte(8'(8'h80 + i));
    bus_read(4'h4, 32'h2E);
    for (int i = 0; i < 16; i++) bus_read(4'h0, 32'(8'h80 + i));
    bus_read(4'h4, 32'h22);
    bus_write(4'h4, 32'h20);
    bus_read(4'h4, 32'h02);

    // 6. Interrupt sources and enables.
    rx_byte(8'h77);
    tick(2);
    check("irq_disabled", {31'b0, irq}, 32'h0);
    bus_write(4'h8, 32'h3);
    tick(3);
    check("irq_rx", {31'b0, irq}, 32'h1);
    bus_read(4'h0, 32'h77);
    tick(3);
    check("irq_tx_empty", {31'b0, irq}, 32'h1);
    bus_write(4'h8, 32'h1);
    tick(3);
    check("irq_off", {31'b0, irq}, 32'h0);
    bus_read(4'h8, 32'h1);
    bus_read(4'hC, 32'h0);

    tick(5);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
